// File: rtl/reg_pipe_vr.sv
// Multi-stage valid/ready register pipeline with bubble collapsing, a synchronous
// flush and a registered occupancy count.
module reg_pipe_vr #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit              DATA_RST  = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_data_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] cap;
  logic [WIDTH-1:0] d [DEPTH];
  logic [CW-1:0]    cnt_next;

  // The downstream port acts as an always-occupied stage whose advance is out_ready_i.
  always_comb begin
    logic nxt_v;
    logic nxt_adv;
    nxt_v   = 1'b1;
    nxt_adv = out_ready_i;
    adv     = '0;
    load    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k]  = v[k] & (~nxt_v | nxt_adv);
      load[k] = ~v[k] | adv[k];
      nxt_v   = v[k];
      nxt_adv = adv[k];
    end
  end

  assign in_ready_o = ~flush_i & load[0];

  always_comb begin
    v_next = v;
    cap    = '0;
    if (flush_i) begin
      v_next = '0;
    end else begin
      if (load[0]) v_next[0] = in_valid_i & in_ready_o;
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) v_next[k] = adv[k-1];
      end
    end
    // Data only moves on a real transfer, and never during a flush.
    cap[0] = in_valid_i & in_ready_o;
    for (int k = 1; k < DEPTH; k++) begin
      cap[k] = adv[k-1] & ~flush_i;
    end
    cnt_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_next = cnt_next + CW'(v_next[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v       <= '0;
      count_o <= '0;
    end else begin
      v       <= v_next;
      count_o <= cnt_next;
    end
  end

  if (DATA_RST) begin : g_data_rst
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) d[k] <= RESET_VAL;
      end else begin
        if (cap[0]) d[0] <= in_data_i;
        for (int k = 1; k < DEPTH; k++) begin
          if (cap[k]) d[k] <= d[k-1];
        end
      end
    end
  end else begin : g_data_nrst
    always_ff @(posedge clk) begin
      if (cap[0]) d[0] <= in_data_i;
      for (int k = 1; k < DEPTH; k++) begin
        if (cap[k]) d[k] <= d[k-1];
      end
    end
  end

  assign out_valid_o = v[DEPTH-1];
  assign out_data_o  = d[DEPTH-1];

endmodule

// File: tb/tb_reg_pipe_vr.sv
// Bench for reg_pipe_vr: directed and random stimulus against a queue model of
// words and their stage positions, on a data-reset and a no-data-reset instance.
module tb_reg_pipe_vr;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready_a, out_valid_a;
  logic [7:0] out_data_a;
  logic [1:0] count_a;
  logic       in_ready_b, out_valid_b;
  logic [7:0] out_data_b;
  logic [1:0] count_b;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] data;
    int         pos;
  } entry_t;

  entry_t q[$];

  always #5 clk = ~clk;

  reg_pipe_vr #(.WIDTH(8), .DEPTH(D), .RESET_VAL(8'hA5), .DATA_RST(1'b1)) dut (
    .clk(clk), .reset(reset), .flush_i(flush),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready_a),
    .out_valid_o(out_valid_a), .out_data_o(out_data_a), .out_ready_i(out_ready),
    .count_o(count_a)
  );

  reg_pipe_vr #(.WIDTH(8), .DEPTH(D), .RESET_VAL(8'hA5), .DATA_RST(1'b0)) dut_nr (
    .clk(clk), .reset(reset), .flush_i(flush),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready_b),
    .out_valid_o(out_valid_b), .out_data_o(out_data_b), .out_ready_i(out_ready),
    .count_o(count_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Model: q holds words oldest first with their stage index. Each edge the
  // oldest word may leave from the last stage, every word moves one stage
  // forward if that leaves it strictly behind the word ahead of it, and a new
  // word enters at stage 0 if stage 0 ends up empty.
  task automatic applyStimulus(input logic iv, input logic [7:0] id,
                               input logic ordy, input logic fl);
    entry_t     nq[$];
    entry_t     e;
    logic       exp_ov, exp_ir, pop;
    logic [7:0] exp_od;
    int         prev;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_ov = (q.size() > 0) && (q[0].pos == D - 1);
    exp_od = (q.size() > 0) ? q[0].data : 8'h00;
    pop    = exp_ov && ordy;
    prev   = D;
    for (int i = (pop ? 1 : 0); i < q.size(); i++) begin
      e = q[i];
      if (e.pos + 1 < prev) e.pos++;
      prev = e.pos;
      nq.push_back(e);
    end
    exp_ir = !fl && ((nq.size() == 0) || (nq[nq.size()-1].pos != 0));

    checkOutput("in_ready",     32'(in_ready_a),  32'(exp_ir));
    checkOutput("out_valid",    32'(out_valid_a), 32'(exp_ov));
    checkOutput("count",        32'(count_a),     32'(q.size()));
    checkOutput("nr_in_ready",  32'(in_ready_b),  32'(exp_ir));
    checkOutput("nr_out_valid", 32'(out_valid_b), 32'(exp_ov));
    checkOutput("nr_count",     32'(count_b),     32'(q.size()));
    if (exp_ov) begin
      checkOutput("out_data",    32'(out_data_a), 32'(exp_od));
      checkOutput("nr_out_data", 32'(out_data_b), 32'(exp_od));
    end

    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      q = nq;
      if (iv && exp_ir) q.push_back('{data: id, pos: 0});
    end
    #1;
  endtask

  task automatic doReset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    #1;
    checkOutput("rst_out_valid",    32'(out_valid_a), 32'd0);
    checkOutput("rst_count",        32'(count_a),     32'd0);
    checkOutput("rst_in_ready",     32'(in_ready_a),  32'd1);
    checkOutput("rst_out_data",     32'(out_data_a),  32'hA5);
    checkOutput("nr_rst_out_valid", 32'(out_valid_b), 32'd0);
    checkOutput("nr_rst_count",     32'(count_b),     32'd0);
    checkOutput("nr_rst_in_ready",  32'(in_ready_b),  32'd1);
    #1;
    reset = 1'b0;
    q.delete();
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #2;
    checkOutput("init_out_valid", 32'(out_valid_a), 32'd0);
    checkOutput("init_count",     32'(count_a),     32'd0);
    checkOutput("init_out_data",  32'(out_data_a),  32'hA5);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)  applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure fills the pipe, then holds, then drains in order
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);

    // Full push and pop together
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with two words held, one of them at the output
    applyStimulus(1'b1, 8'h30, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Async reset while full and stalled, then a fresh word through
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    doReset();
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomised traffic with occasional flush and mid-cycle reset
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 149) == 0) doReset();
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
